cpu_exec_core: RTL and testbench
================================

// Module: cpu_exec_core
// PURPOSE
//  Sequencer, decoder and ALU of the 16-bit microsys CPU datapath, instantiated as one block.
//  A 4-state one-hot sequencer runs DECODE -> REGREAD -> ALU -> REGWRITE; one instruction takes 4 clocks.
//  Drives register-file selects and write enable to an external 8x16 register file, and consumes its two
//  read ports. Branch target and flag go to the fetch logic; PC is an input.
// PARAMETERS
//  (none; widths fixed: 16-bit data, 8 registers, 4-bit opcode)
// PORTS
//  clk            in   1   rising-edge clock
//  reset          in   1   asynchronous, active-high reset
//  instruction    in   16  instruction word; sampled in DECODE
//  pc             in   16  current PC (reserved for PC-relative use; JUMP ignores it)
//  data_a         in   16  register-file read port A (rA)
//  data_b         in   16  register-file read port B (rB)
//  state          out  4   one-hot: [0]DECODE [1]REGREAD [2]ALU [3]REGWRITE
//  sel_a,sel_b    out  3   read selects rA, rB
//  sel_d          out  3   write select rD
//  data_result    out  16  ALU result / branch target; write data to register file
//  reg_we         out  1   register write strobe = write_reg & state[3]
//  should_branch  out  1   branch taken (valid from ALU until next ALU state)
// BEHAVIOUR
//  Reset: state=4'b0001; sel_*=0, imm=0, alu_op=0, data_result=0, write_reg=0, should_branch=0.
//  Sequencer: rotates left once per clock (0001->0010->0100->1000->0001). No stalls.
//  Decode (registered when state[0]):
//   opcode=inst[15:12], rD=inst[11:9], flag=inst[8], rA=inst[7:5], rB=inst[4:2], imm={inst[7:0],inst[7:0]}.
//   alu_op={opcode,flag}.
//  Register file is external: it presents data_a/data_b by the ALU state.
//  ALU (registered when state[2]); write_reg=1 unless noted; widths mod 2^16:
//   0000 ADD  a+b (flag: 1=signed; bit pattern same)
//   0001 SUB  a-b
//   0010 OR   a|b
//   0011 XOR  a^b
//   0100 AND  a&b
//   0101 NOT  ~a
//   0110/0111 READ/WRITE: reserved for memory unit; result 0, write_reg=0
//   1000 LOAD flag=0: {imm[7:0],8'h00}; flag=1: {8'h00,imm[7:0]}
//   1001 CMP  [15]a==b [14]a>b [13]a<b [12]a==0 [11]b==0, rest 0; flag=1 signed compares
//   1010 SHL  a<<b[3:0]
//   1011 SHR  a>>b[3:0] (flag=1 arithmetic)
//   1100 JUMP result = flag? imm : a; should_branch=1; write_reg=0
//   1101 JUMPZ result = b; should_branch=(a==0); write_reg=0
//   1110/1111 reserved: result 0, write_reg=0, should_branch=0
//  should_branch cleared on every ALU state whose op is not a branch.
//  Reset mid-instruction: all state returns to reset values immediately; next DECODE on the first edge after release.
//  Instruction changes outside DECODE are ignored.
// CONFIGURATION
//  CPU_EXEC_SHIFT_EN defined: SHL/SHR as above.
//  Not defined: opcodes 1010/1011 behave as reserved (result 0, write_reg=0).
// STRUCTURE
//  Package cpu_pkg: OPCODE_* localparams, state one-hot constants, field-position constants.
//  One sub-module cpu_alu (combinational op mux + output registers). Sequencer and decode stay inline.
// TESTING
//  Sequence: each instruction is applied before REGWRITE; a behavioural 8x16 register file is wired to sel_*/reg_we.
//  1 reset, release -> state 0001,0010,0100,1000,0001; reg_we never high in first 3 states.
//  2 LOAD r0 flag0 imm FE -> r0=FE00; LOAD r1 flag1 imm ED -> r1=00ED; OR r2,r0,r1 -> r2=FEED.
//  3 LOAD.l r3=1, r4=2; ADD r3,r3,r4 -> r3=0003; OR r5,r0,r3 -> r5=FE03.
//  4 CMP r6,r3,r4 (3 vs 2) -> r6=4000; SUB 0000-0001 -> FFFF (wrap).
//  5 JUMP flag1 imm 40 -> should_branch=1, data_result=4040, no register written.
//  5 JUMPZ with a=0 -> should_branch=1; with a=1 -> 0.
//  6 reset asserted in ALU state -> state=0001 and data_result=0 at once; no reg_we pulse.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcodes, sequencer states and instruction field positions for cpu_exec_core.
package cpu_pkg;

  localparam logic [3:0] OPCODE_ADD   = 4'b0000;
  localparam logic [3:0] OPCODE_SUB   = 4'b0001;
  localparam logic [3:0] OPCODE_OR    = 4'b0010;
  localparam logic [3:0] OPCODE_XOR   = 4'b0011;
  localparam logic [3:0] OPCODE_AND   = 4'b0100;
  localparam logic [3:0] OPCODE_NOT   = 4'b0101;
  localparam logic [3:0] OPCODE_READ  = 4'b0110;
  localparam logic [3:0] OPCODE_WRITE = 4'b0111;
  localparam logic [3:0] OPCODE_LOAD  = 4'b1000;
  localparam logic [3:0] OPCODE_CMP   = 4'b1001;
  localparam logic [3:0] OPCODE_SHL   = 4'b1010;
  localparam logic [3:0] OPCODE_SHR   = 4'b1011;
  localparam logic [3:0] OPCODE_JUMP  = 4'b1100;
  localparam logic [3:0] OPCODE_JUMPZ = 4'b1101;

  // Instruction word field positions (LSB of each field).
  localparam int OP_LSB   = 12;
  localparam int RD_LSB   = 9;
  localparam int FLAG_BIT = 8;
  localparam int RA_LSB   = 5;
  localparam int RB_LSB   = 2;

  typedef enum logic [3:0] {
    ST_DECODE   = 4'b0001,
    ST_REGREAD  = 4'b0010,
    ST_ALU      = 4'b0100,
    ST_REGWRITE = 4'b1000
  } state_t;

endpackage

// File: rtl/cpu_exec_core_if.sv
// Signal bundle between cpu_exec_core and its fetch logic / external 8x16 register file.
interface cpu_exec_core_if;
  // No valid/ready: the core runs a fixed 4-clock cadence. instruction must be stable
  // while state==DECODE, data_a/data_b must reflect sel_a/sel_b by the ALU state, and
  // the register file writes data_result to sel_d on the clock edge ending REGWRITE
  // whenever reg_we is high.
  logic [15:0] instruction;
  logic [15:0] pc;
  logic [15:0] data_a;
  logic [15:0] data_b;
  logic [3:0]  state;
  logic [2:0]  sel_a;
  logic [2:0]  sel_b;
  logic [2:0]  sel_d;
  logic [15:0] data_result;
  logic        reg_we;
  logic        should_branch;

  modport master (
    input  instruction, pc, data_a, data_b,
    output state, sel_a, sel_b, sel_d, data_result, reg_we, should_branch
  );

  modport slave (
    output instruction, pc, data_a, data_b,
    input  state, sel_a, sel_b, sel_d, data_result, reg_we, should_branch
  );
endinterface

// File: rtl/cpu_alu.sv
// ALU op mux with registered result, write-enable and branch flag.
// Macro CPU_EXEC_SHIFT_EN enables SHL/SHR; otherwise those opcodes act as reserved.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_en,
  input  logic [4:0]  i_alu_op,
  input  logic [15:0] i_imm,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_result,
  output logic        o_write_reg,
  output logic        o_should_branch
);

  logic [3:0]  w_opcode;
  logic        w_flag;
  logic [15:0] w_result;
  logic        w_write_reg;
  logic        w_branch;
  logic        w_gt;
  logic        w_lt;

  assign w_opcode = i_alu_op[4:1];
  assign w_flag   = i_alu_op[0];
  assign w_gt     = w_flag ? ($signed(i_a) > $signed(i_b)) : (i_a > i_b);
  assign w_lt     = w_flag ? ($signed(i_a) < $signed(i_b)) : (i_a < i_b);

  always_comb begin
    w_result    = 16'h0000;
    w_write_reg = 1'b0;
    w_branch    = 1'b0;
    case (w_opcode)
      OPCODE_ADD: begin w_result = i_a + i_b; w_write_reg = 1'b1; end
      OPCODE_SUB: begin w_result = i_a - i_b; w_write_reg = 1'b1; end
      OPCODE_OR:  begin w_result = i_a | i_b; w_write_reg = 1'b1; end
      OPCODE_XOR: begin w_result = i_a ^ i_b; w_write_reg = 1'b1; end
      OPCODE_AND: begin w_result = i_a & i_b; w_write_reg = 1'b1; end
      OPCODE_NOT: begin w_result = ~i_a;      w_write_reg = 1'b1; end
      OPCODE_LOAD: begin
        w_result    = w_flag ? {8'h00, i_imm[7:0]} : {i_imm[7:0], 8'h00};
        w_write_reg = 1'b1;
      end
      OPCODE_CMP: begin
        w_result    = {i_a == i_b, w_gt, w_lt, i_a == 16'h0000, i_b == 16'h0000, 11'b0};
        w_write_reg = 1'b1;
      end
`ifdef CPU_EXEC_SHIFT_EN
      OPCODE_SHL: begin w_result = i_a << i_b[3:0]; w_write_reg = 1'b1; end
      OPCODE_SHR: begin
        w_result    = w_flag ? 16'($signed(i_a) >>> i_b[3:0]) : (i_a >> i_b[3:0]);
        w_write_reg = 1'b1;
      end
`endif
      OPCODE_JUMP: begin
        w_result = w_flag ? i_imm : i_a;
        w_branch = 1'b1;
      end
      OPCODE_JUMPZ: begin
        w_result = i_b;
        w_branch = (i_a == 16'h0000);
      end
      default: begin
        w_result    = 16'h0000;
        w_write_reg = 1'b0;
        w_branch    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_result        <= 16'h0000;
      o_write_reg     <= 1'b0;
      o_should_branch <= 1'b0;
    end else if (i_en) begin
      o_result        <= w_result;
      o_write_reg     <= w_write_reg;
      o_should_branch <= w_branch;
    end
  end

endmodule

// File: rtl/cpu_exec_core.sv
// Sequencer + decoder of the microsys CPU; ALU in cpu_alu.
// Macro CPU_EXEC_SHIFT_EN (passed through to cpu_alu) enables SHL/SHR.
module cpu_exec_core
  import cpu_pkg::*;
(
  input logic         clk,
  input logic         reset,
  cpu_exec_core_if.master bus
);

  state_t      r_state;
  logic [3:0]  w_state;
  logic [2:0]  r_sel_a;
  logic [2:0]  r_sel_b;
  logic [2:0]  r_sel_d;
  logic [15:0] r_imm;
  logic [4:0]  r_alu_op;
  logic [15:0] w_result;
  logic        w_write_reg;
  logic        w_should_branch;
  logic        w_unused_pc;

  assign w_state = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_DECODE;
      r_sel_a  <= 3'd0;
      r_sel_b  <= 3'd0;
      r_sel_d  <= 3'd0;
      r_imm    <= 16'h0000;
      r_alu_op <= 5'd0;
    end else begin
      case (r_state)
        ST_DECODE:   r_state <= ST_REGREAD;
        ST_REGREAD:  r_state <= ST_ALU;
        ST_ALU:      r_state <= ST_REGWRITE;
        ST_REGWRITE: r_state <= ST_DECODE;
        default:     r_state <= ST_DECODE;
      endcase
      // Decode fields are only captured in DECODE; the instruction bus is ignored elsewhere.
      if (r_state == ST_DECODE) begin
        r_sel_d  <= bus.instruction[RD_LSB +: 3];
        r_sel_a  <= bus.instruction[RA_LSB +: 3];
        r_sel_b  <= bus.instruction[RB_LSB +: 3];
        r_imm    <= {bus.instruction[7:0], bus.instruction[7:0]};
        r_alu_op <= {bus.instruction[OP_LSB +: 4], bus.instruction[FLAG_BIT]};
      end
    end
  end

  cpu_alu u_alu (
    .clk             (clk),
    .reset           (reset),
    .i_en            (w_state[2]),
    .i_alu_op        (r_alu_op),
    .i_imm           (r_imm),
    .i_a             (bus.data_a),
    .i_b             (bus.data_b),
    .o_result        (w_result),
    .o_write_reg     (w_write_reg),
    .o_should_branch (w_should_branch)
  );

  // PC is reserved for future PC-relative ops; JUMP targets do not depend on it.
  assign w_unused_pc = ^bus.pc;

  assign bus.state         = w_state;
  assign bus.sel_a         = r_sel_a;
  assign bus.sel_b         = r_sel_b;
  assign bus.sel_d         = r_sel_d;
  assign bus.data_result   = w_result;
  assign bus.reg_we        = w_write_reg & w_state[3];
  assign bus.should_branch = w_should_branch;

endmodule

// File: tb/tb_cpu_exec_core.sv
// Testbench for cpu_exec_core: behavioural register file, reference model and REGWRITE scoreboard.
module tb_cpu_exec_core;

  localparam int W = 21;  // {sel_d, reg_we, should_branch, data_result}

  logic clk = 1'b0;
  logic reset;
  cpu_exec_core_if bus();

  cpu_exec_core dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural register file ----------------
  logic [15:0] tb_rf [8] = '{default: 16'h0000};
  assign bus.data_a = tb_rf[bus.sel_a];
  assign bus.data_b = tb_rf[bus.sel_b];
  always @(posedge clk) if (bus.reg_we) tb_rf[bus.sel_d] <= bus.data_result;

  // ---------------- scoreboard state ----------------
  logic [15:0] model_rf [8] = '{default: 16'h0000};
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: executes one instruction against model_rf at the ISA level.
  function automatic logic [W-1:0] model(input logic [15:0] ins);
    logic [3:0]  op;
    logic [2:0]  rd;
    logic        f;
    logic [7:0]  k;
    logic [15:0] a, b, res;
    logic        we, br;
    int          sa, sb, sh, v;
    longint      lv;
    op = ins[15:12]; rd = ins[11:9]; f = ins[8]; k = ins[7:0];
    a = model_rf[ins[7:5]]; b = model_rf[ins[4:2]];
    sa = a[15] ? int'(a) - 65536 : int'(a);
    sb = b[15] ? int'(b) - 65536 : int'(b);
    sh = int'(b[3:0]);
    res = 16'h0; we = 1'b0; br = 1'b0; v = 0; lv = 0;
    case (op)
      4'd0:  begin v = (int'(a) + int'(b)) % 65536;         res = v[15:0]; we = 1; end
      4'd1:  begin v = (int'(a) - int'(b) + 65536) % 65536; res = v[15:0]; we = 1; end
      4'd2:  begin res = a | b; we = 1; end
      4'd3:  begin res = a ^ b; we = 1; end
      4'd4:  begin res = a & b; we = 1; end
      4'd5:  begin v = 65535 - int'(a); res = v[15:0]; we = 1; end
      4'd8:  begin res = f ? {8'h00, k} : {k, 8'h00}; we = 1; end
      4'd9:  begin
        res[15] = (a == b);
        res[14] = f ? (sa > sb) : (int'(a) > int'(b));
        res[13] = f ? (sa < sb) : (int'(a) < int'(b));
        res[12] = (a == 0);
        res[11] = (b == 0);
        we = 1;
      end
`ifdef CPU_EXEC_SHIFT_EN
      4'd10: begin lv = (longint'(a) * (longint'(1) << sh)) % 65536; res = lv[15:0]; we = 1; end
      4'd11: begin v = f ? (sa >>> sh) : (int'(a) / (1 << sh)); res = v[15:0]; we = 1; end
`endif
      4'd12: begin res = f ? {k, k} : a; br = 1; end
      4'd13: begin res = b; br = (a == 0); end
      default: begin res = 16'h0; we = 0; br = 0; end
    endcase
    return {rd, we, br, res};
  endfunction

  task automatic expect_instr(input logic [15:0] ins);
    logic [W-1:0] e;
    e = model(ins);
    exp_q.push_back(e);
    if (e[17]) model_rf[e[20:18]] = e[15:0];
  endtask

  task automatic wait_state(input logic [3:0] s);
    int n;
    n = 0;
    while (bus.state !== s && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.state !== s) check("wait_state_timeout", {28'h0, bus.state}, {28'h0, s});
  endtask

  // Present ins for one DECODE, then scramble the bus to show it is ignored afterwards.
  task automatic issue(input logic [15:0] ins, input bit push);
    wait_state(4'b0001);
    bus.instruction = ins;
    if (push) expect_instr(ins);
    @(posedge clk);
    #1;
    bus.instruction = 16'($urandom);
    bus.pc          = 16'($urandom);
  endtask

  task automatic check_reg(input int idx, input logic [15:0] val, input string name);
    wait_state(4'b0001);
    check(name, {16'h0, tb_rf[idx]}, {16'h0, val});
  endtask

  function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd,
                                        input logic f, input logic [2:0] ra, input logic [2:0] rb);
    return {op, rd, f, ra, rb, 2'b00};
  endfunction

  function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rd,
                                        input logic f, input logic [7:0] k);
    return {op, rd, f, k};
  endfunction

  // ---------------- monitor ----------------
  logic [W-1:0] mon_exp;
  logic [W-1:0] mon_got;
  always @(negedge clk) begin
    if (!reset) begin
      check("reg_we_outside_regwrite", {31'h0, bus.reg_we && (bus.state != 4'b1000)}, 32'h0);
      if (bus.state == 4'b1000) begin
        mon_got = {bus.sel_d, bus.reg_we, bus.should_branch, bus.data_result};
        if (exp_q.size() == 0) begin
          check("unexpected_regwrite", {11'h0, mon_got}, 32'hFFFF_FFFF);
        end else begin
          mon_exp = exp_q.pop_front();
          check("regwrite_outputs", {11'h0, mon_got}, {11'h0, mon_exp});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    bus.instruction = 16'hE000;
    bus.pc = 16'($urandom);
    repeat (2) @(negedge clk);
    check("reset_state", {28'h0, bus.state}, 32'h1);
    check("reset_data_result", {16'h0, bus.data_result}, 32'h0);
    check("reset_should_branch", {31'h0, bus.should_branch}, 32'h0);
    check("reset_reg_we", {31'h0, bus.reg_we}, 32'h0);
    check("reset_sels", {23'h0, bus.sel_a, bus.sel_b, bus.sel_d}, 32'h0);

    // Reserved opcode keeps the first pass through the sequencer free of writes.
    expect_instr(16'hE000);
    reset = 1'b0;
    @(negedge clk); check("seq_1", {28'h0, bus.state}, 32'h2);
    @(negedge clk); check("seq_2", {28'h0, bus.state}, 32'h4);
    @(negedge clk); check("seq_3", {28'h0, bus.state}, 32'h8);
    @(negedge clk); check("seq_4", {28'h0, bus.state}, 32'h1);

    issue(enc_i(4'h8, 3'd0, 1'b0, 8'hFE), 1);
    issue(enc_i(4'h8, 3'd1, 1'b1, 8'hED), 1);
    issue(enc_r(4'h2, 3'd2, 1'b0, 3'd0, 3'd1), 1);
    check_reg(0, 16'hFE00, "load_hi_r0");
    check_reg(1, 16'h00ED, "load_lo_r1");
    check_reg(2, 16'hFEED, "or_r2");

    issue(enc_i(4'h8, 3'd3, 1'b1, 8'h01), 1);
    issue(enc_i(4'h8, 3'd4, 1'b1, 8'h02), 1);
    issue(enc_r(4'h0, 3'd3, 1'b0, 3'd3, 3'd4), 1);
    issue(enc_r(4'h2, 3'd5, 1'b0, 3'd0, 3'd3), 1);
    check_reg(3, 16'h0003, "add_r3");
    check_reg(5, 16'hFE03, "or_r5");

    issue(enc_r(4'h9, 3'd6, 1'b0, 3'd3, 3'd4), 1);
    check_reg(6, 16'h4000, "cmp_r6");

    issue(enc_i(4'h8, 3'd7, 1'b1, 8'h00), 1);
    issue(enc_i(4'h8, 3'd1, 1'b1, 8'h01), 1);
    issue(enc_r(4'h1, 3'd2, 1'b0, 3'd7, 3'd1), 1);
    check_reg(2, 16'hFFFF, "sub_wrap_r2");

    issue(enc_i(4'hC, 3'd0, 1'b1, 8'h40), 1);
    wait_state(4'b1000);
    check("jump_branch", {31'h0, bus.should_branch}, 32'h1);
    check("jump_target", {16'h0, bus.data_result}, 32'h4040);
    check("jump_no_we", {31'h0, bus.reg_we}, 32'h0);

    issue(enc_r(4'hD, 3'd0, 1'b0, 3'd7, 3'd2), 1);
    wait_state(4'b1000);
    check("jumpz_taken", {31'h0, bus.should_branch}, 32'h1);
    issue(enc_r(4'hD, 3'd0, 1'b0, 3'd1, 3'd2), 1);
    wait_state(4'b1000);
    check("jumpz_not_taken", {31'h0, bus.should_branch}, 32'h0);

    // Reset in the ALU state of a LOAD r7 that must never be written.
    issue(enc_i(4'hC, 3'd0, 1'b1, 8'h40), 1);
    issue(enc_i(4'h8, 3'd7, 1'b0, 8'h55), 0);
    wait_state(4'b0100);
    reset = 1'b1;
    #1;
    check("midreset_state", {28'h0, bus.state}, 32'h1);
    check("midreset_data_result", {16'h0, bus.data_result}, 32'h0);
    check("midreset_should_branch", {31'h0, bus.should_branch}, 32'h0);
    check("midreset_reg_we", {31'h0, bus.reg_we}, 32'h0);
    repeat (2) @(negedge clk);
    bus.instruction = enc_r(4'h5, 3'd6, 1'b0, 3'd3, 3'd0);
    expect_instr(bus.instruction);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_first_decode", {28'h0, bus.state}, 32'h2);
    bus.instruction = 16'($urandom);
    check_reg(7, 16'h0000, "midreset_no_write_r7");
    check_reg(6, 16'hFFFC, "not_r6");

    for (int i = 0; i < 60; i++) issue(16'($urandom), 1);

    wait_state(4'b0001);
    for (int i = 0; i < 8; i++) check($sformatf("final_rf_r%0d", i), {16'h0, tb_rf[i]}, {16'h0, model_rf[i]});
    check("scoreboard_drained", exp_q.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
